// File: rtl/seq_arb_pkg.sv
// Shared types and helpers for the bounded-hold round-robin arbiter.
// One-hot request vector type, priority rotation, and hold-counter width.
package seq_arb_pkg;

    typedef logic [3:0] onehot4_t;

    // The requester after the granted one becomes top priority.
    function automatic onehot4_t rotl4(input onehot4_t v);
        return {v[2:0], v[3]};
    endfunction

    function automatic int cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/arb_4in_rr_pick.sv
// Combinational round-robin pick: first set request scanning upward from the
// one-hot priority position, wrapping from 3 back to 0.
module arb_4in_rr_pick
    import seq_arb_pkg::*;
(
    input  logic [3:0] reqs_i,
    input  onehot4_t   prio_i,
    output onehot4_t   pick_o
);

    logic [1:0] base;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        base = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (prio_i[i]) base = 2'(i);
        end
    end

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && reqs_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_arb_4in_boundhold.sv
// Four-input round-robin arbiter where the granted requester may hold
// ownership via its hold bit, capped at MAX_HOLD consecutive cycles.
module seq_arb_4in_boundhold
    import seq_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] reqs,
    input  logic [3:0] holds,
    output logic [3:0] grants
);

    localparam int CNT_W = cnt_width(MAX_HOLD);

    onehot4_t         prio_q, prio_d;
    logic             locked_q, locked_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    onehot4_t         pick;
    logic             keep;
    logic [CNT_W-1:0] tenure;
    logic [1:0]       gidx;

    arb_4in_rr_pick u_pick (
        .reqs_i (reqs),
        .prio_i (prio_q),
        .pick_o (pick)
    );

    // A locked owner that dropped its request falls through to fresh arbitration.
    assign keep = locked_q && reqs[owner_q];

    always_comb begin
        grants = '0;
        tenure = CNT_W'(1);
        if (reset) begin
            grants = '0;
        end else if (keep) begin
            grants = 4'(1) << owner_q;
            tenure = cnt_q + CNT_W'(1);
        end else begin
            grants = pick;
        end
    end

    always_comb begin
        gidx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grants[i]) gidx = 2'(i);
        end
    end

    always_comb begin
        prio_d   = prio_q;
        locked_d = 1'b0;
        owner_d  = owner_q;
        cnt_d    = '0;
        if (grants != 4'b0000) begin
            if (holds[gidx] && (tenure < CNT_W'(MAX_HOLD))) begin
                locked_d = 1'b1;
                owner_d  = gidx;
                cnt_d    = tenure;
            end else begin
                prio_d = rotl4(grants);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q   <= 4'b0001;
            locked_q <= 1'b0;
            owner_q  <= 2'd0;
            cnt_q    <= '0;
        end else begin
            prio_q   <= prio_d;
            locked_q <= locked_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_arb_4in_boundhold.sv
// Bench for seq_arb_4in_boundhold: directed vector table, then random traffic
// against a cycle-level reference model, all through an expected-grant queue.
module tb_seq_arb_4in_boundhold;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] reqs = '0;
    logic [3:0] holds = '0;
    logic [3:0] grants;

    seq_arb_4in_boundhold #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .reset  (rst),
        .reqs   (reqs),
        .holds  (holds),
        .grants (grants)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic [3:0] hd;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        bit         rnd;
        int         tag;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   checks = 0;
    int   failures = 0;
    int   run_len = 0;
    logic [3:0] prev_g = '0;

    // Reference model state (index-based priority)
    int m_pri = 0;
    bit m_lock = 0;
    int m_owner = 0;
    int m_cnt = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] hd,
                                input logic [3:0] e);
        vec_t v;
        v.r = r; v.rq = rq; v.hd = hd; v.exp = e;
        return v;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] rq, input logic [3:0] hd,
                              output logic [3:0] g);
        int w;
        int ten;
        g = '0;
        if (r) begin
            m_pri = 0; m_lock = 0; m_owner = 0; m_cnt = 0;
            return;
        end
        w = -1;
        ten = 1;
        if (m_lock && rq[m_owner]) begin
            w = m_owner;
            ten = m_cnt + 1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_pri + k) % 4;
                if (w < 0 && rq[j]) w = j;
            end
        end
        if (w < 0) begin
            m_lock = 0; m_cnt = 0;
        end else begin
            g[w] = 1'b1;
            if (hd[w] && ten < MAX_HOLD) begin
                m_lock = 1; m_owner = w; m_cnt = ten;
            end else begin
                m_lock = 0; m_cnt = 0; m_pri = (w + 1) % 4;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] hd,
                         input logic [3:0] e, input bit rnd, input int tag);
        sb_t s;
        @(posedge clk);
        #1;
        rst = r; reqs = rq; holds = hd;
        s.exp = e; s.rnd = rnd; s.tag = tag;
        sb.push_back(s);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t s;
            s = sb.pop_front();
            checks++;
            if (grants !== s.exp) begin
                failures++;
                $display("FAIL %s %0d: grants=%b expected=%b (reqs=%b holds=%b reset=%b)",
                         s.rnd ? "rand" : "vec", s.tag, grants, s.exp, reqs, holds, rst);
            end
            checks++;
            if ((grants & (grants - 4'd1)) != 4'd0 || (grants & ~reqs) != 4'd0) begin
                failures++;
                $display("FAIL onehot_subset %0d: grants=%b reqs=%b required one-hot subset",
                         s.tag, grants, reqs);
            end
            if (grants != 4'd0 && grants == prev_g) run_len++;
            else run_len = (grants != 4'd0) ? 1 : 0;
            prev_g = grants;
            if ((reqs & ~grants) != 4'd0 && grants != 4'd0) begin
                checks++;
                if (run_len > MAX_HOLD) begin
                    failures++;
                    $display("FAIL hold_bound %0d: run=%0d grants=%b required run<=%0d",
                             s.tag, run_len, grants, MAX_HOLD);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        logic       r;
        logic [3:0] rq;
        logic [3:0] hd;

        // No holds: plain rotation
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001));
        // Bounded hold
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0001));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0010));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0100));
        // Short hold
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 4'b0001));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 4'b0001));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010));
        // Owner drops request
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0010));
        tbl.push_back(mk(0, 4'b0101, 4'b0000, 4'b0001));
        tbl.push_back(mk(0, 4'b0101, 4'b0000, 4'b0100));
        // Idle and reset mid-lock
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100));
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100));
        // Holds of non-granted requesters are ignored
        tbl.push_back(mk(0, 4'b0011, 4'b1100, 4'b0001));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 4'b0010));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].rq, tbl[i].hd, tbl[i].exp, 1'b0, i);
        end

        // Random traffic, starting from a reset so the model is in step
        model_step(1'b1, 4'b0000, 4'b0000, g);
        drive(1'b1, 4'b0000, 4'b0000, g, 1'b1, 0);
        for (int i = 1; i <= 200; i++) begin
            r  = ($urandom_range(0, 15) == 0);
            rq = 4'($urandom_range(0, 15));
            hd = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            model_step(r, rq, hd, g);
            drive(r, rq, hd, g, 1'b1, i);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
